// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_pkg: shared types and helpers for the load/store unit.
//   - size encodings, controller state enum, latched request payload
//   - misalignment check, byte-enable/lane helpers, load extension
package data_mem_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Request payload captured on accept.
  typedef struct packed {
    logic            write;
    logic [1:0]      size;
    logic            is_signed;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } req_t;

  // Misaligned half/word or the reserved size encoding.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = lane[0];
      SZ_WORD: err = (lane != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  // Byte enables for an aligned access of the given size at the given lane.
  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the LSB-aligned store data across every lane it could land in.
  function automatic logic [XLEN-1:0] lane_wdata(input logic [1:0] size, input logic [XLEN-1:0] wdata);
    logic [XLEN-1:0] d;
    case (size)
      SZ_BYTE: d = {4{wdata[7:0]}};
      SZ_HALF: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  // Select the addressed lane of a read word and sign/zero-extend it.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                  input logic [1:0]      size,
                                                  input logic [1:0]      lane,
                                                  input logic            is_signed);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] r;
    sh = word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: r = {{24{is_signed & sh[7]}}, sh[7:0]};
      SZ_HALF: r = {{16{is_signed & sh[15]}}, sh[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: request/response bus between the core and the load/store unit.
//   master: drives req_*; observes req_ready, rsp_*, busy
//   slave : the load/store unit
interface data_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/data_mem_array.sv
// data_mem_array: DEPTH_WORDS x 32 storage, synchronous byte-enable write and
// synchronous read, both qualified by en_i. Contents are not reset.
//   clk     : clock
//   en_i    : access strobe (one cycle)
//   we_i    : write the enabled bytes
//   be_i    : byte enables, bit n = byte lane n
//   addr_i  : word index
//   wdata_i : lane-replicated write data
//   rdata_o : word read on the last enabled edge (pre-write value)
module data_mem_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = 8
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Storage port; read returns the word as it was before this edge's write.
  always_ff @(posedge clk) begin
    if (en_i) begin
      rdata_q <= mem_q[addr_i];
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store unit with WAIT_CYCLES wait states in front of a
// byte-addressed little-endian data memory.
//   clk, rst_n : clock, async active-low reset
//   bus        : data_mem_ctrl_if.slave (request handshake, response pulse, busy stall)
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  data_mem_ctrl_if.slave   bus
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAST_WAIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  req_t        req_q;
  logic        ready_q;
  logic        busy_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;

  req_t          live_c;
  req_t          acc_c;
  logic          accept_c;
  logic          enter_resp_c;
  logic          acc_err_c;
  logic          mem_en_c;
  logic          mem_we_c;
  logic [3:0]    mem_be_c;
  logic [31:0]   mem_wdata_c;
  logic [AW-1:0] mem_addr_c;
  logic [31:0]   mem_rdata;
  logic          unused_addr_c;

  // Access decode. In IDLE the live request is used so that a zero-wait
  // access can reach the memory on its accept edge; otherwise the latched one.
  always_comb begin
    live_c.write     = bus.req_write;
    live_c.size      = bus.req_size;
    live_c.is_signed = bus.req_signed;
    live_c.addr      = bus.req_addr;
    live_c.wdata     = bus.req_wdata;

    accept_c     = bus.req_valid && ready_q;
    acc_c        = (state_q == IDLE) ? live_c : req_q;
    enter_resp_c = ((state_q == IDLE) && accept_c && (WAIT_CYCLES == 0)) ||
                   ((state_q == WAIT) && (cnt_q == LAST_WAIT));
    acc_err_c    = is_misaligned(acc_c.size, acc_c.addr[1:0]);

    // rst_n gate keeps a request presented during reset from touching memory.
    mem_en_c     = enter_resp_c && rst_n;
    mem_we_c     = acc_c.write && !acc_err_c;
    mem_be_c     = byte_enable(acc_c.size, acc_c.addr[1:0]);
    mem_wdata_c  = lane_wdata(acc_c.size, acc_c.wdata);
    mem_addr_c   = acc_c.addr[AW+1:2];
  end

  // Address bits above the word index wrap away.
  assign unused_addr_c = ^acc_c.addr[31:AW+2];

  // Controller FSM with registered handshake/response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      req_q       <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            req_q   <= live_c;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= 4'd0;
            if (WAIT_CYCLES == 0) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= acc_err_c;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == LAST_WAIT) begin
            state_q     <= RESP;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= acc_err_c;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  data_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .en_i    (mem_en_c),
    .we_i    (mem_we_c),
    .be_i    (mem_be_c),
    .addr_i  (mem_addr_c),
    .wdata_i (mem_wdata_c),
    .rdata_o (mem_rdata)
  );

  assign bus.req_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;

  // Load data is only driven during the good-load response cycle.
  assign bus.rsp_rdata = (rsp_valid_q && !rsp_err_q && !req_q.write)
                         ? load_extend(mem_rdata, req_q.size, req_q.addr[1:0], req_q.is_signed)
                         : 32'd0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed vector table, handshake/reset sequences and a
// randomized phase checked against a byte-array reference model.
module tb_data_mem_ctrl;

  localparam int unsigned DEPTH = 256;
  localparam int          W     = 2;
  localparam int          NBYTE = DEPTH * 4;

  logic clk;
  logic rst_n;

  data_mem_ctrl_if bus ();

  data_mem_ctrl #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_CYCLES (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ref_b [NBYTE];

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic sg,
                              input logic [31:0] ad, input logic [31:0] wd,
                              input logic [31:0] exp_rd, input logic exp_er);
    vec_t v;
    v.wr = wr; v.sz = sz; v.sg = sg; v.ad = ad; v.wd = wd;
    v.exp_rd = exp_rd; v.exp_er = exp_er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%h (%0d) required=0x%h (%0d)", nm, act, act, exp, exp);
    end
  endtask

  // Reference: byte-addressed little-endian memory, wrap modulo NBYTE.
  task automatic model_access(input logic wr, input logic [1:0] sz, input logic sg,
                              input logic [31:0] ad, input logic [31:0] wd,
                              output logic [31:0] rd, output logic er);
    int          a;
    int          n;
    logic [31:0] v;
    a  = int'(ad % 32'(NBYTE));
    n  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    er = (sz == 2'b11) || ((ad % 32'(n)) != 32'd0);
    rd = 32'd0;
    if (!er) begin
      if (wr) begin
        for (int i = 0; i < n; i++) ref_b[a + i] = 8'(wd >> (8 * i));
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_b[a + i]) << (8 * i));
        if (sg && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        rd = v;
      end
    end
  endtask

  // One request through the handshake; records the response and busy profile.
  task automatic do_access(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] ad, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er,
                           output int busy_n, output int resp_at, output int n_rsp,
                           output int stray);
    int guard;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = ad;
    bus.req_wdata  = wd;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) chk("accept_timeout", 32'(guard), 32'd0);
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'($urandom);
    bus.req_size   = 2'($urandom);
    bus.req_signed = 1'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    busy_n = 0; resp_at = -1; n_rsp = 0; stray = 0; rd = 32'd0; er = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!bus.busy) break;
      busy_n++;
      if (bus.rsp_valid) begin
        n_rsp++;
        resp_at = busy_n;
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
      end else if (bus.rsp_rdata !== 32'd0 || bus.rsp_err !== 1'b0) begin
        stray++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_check(input string nm, input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] ad, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd;
    logic        er;
    int          bn, ra, nr, st;
    do_access(wr, sz, sg, ad, wd, rd, er, bn, ra, nr, st);
    chk({nm, "_rdata"}, rd, exp_rd);
    chk({nm, "_err"}, 32'(er), 32'(exp_er));
    // busy cycles / position of the response pulse / number of pulses
    chk({nm, "_timing"}, 32'(bn * 100 + ra * 10 + nr), 32'((W + 1) * 100 + (W + 1) * 10 + 1));
    chk({nm, "_idle_rsp"}, 32'(st), 32'd0);
  endtask

  initial begin
    logic [31:0] erd;
    logic        eer;
    int          bad_ready, bad_busy, pulses, g;

    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: {write, size, signed, addr, wdata, expected rdata, expected err}
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h20,  32'h80FF7F01, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h21,  32'h0,        32'h0000007F, 1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h23,  32'h0,        32'hFFFFFF80, 1'b0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h22,  32'h0,        32'hFFFF80FF, 1'b0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h22,  32'h0,        32'h000080FF, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h20,  32'h11223344, 32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h21,  32'h000000AA, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'h1122AA44, 1'b0));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h22,  32'h0,        32'h0,        1'b1));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h30,  32'hCAFEF00D, 32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h31,  32'h0000BEEF, 32'h0,        1'b1));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h30,  32'h0,        32'hCAFEF00D, 1'b0));
    vecs.push_back(mk(1'b0, 2'b11, 1'b0, 32'h30,  32'h0,        32'h0,        1'b1));
    vecs.push_back(mk(1'b1, 2'b11, 1'b0, 32'h30,  32'h55555555, 32'h0,        1'b1));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h30,  32'h0,        32'hCAFEF00D, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h400, 32'h5A5AA5A5, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h000, 32'h0,        32'h5A5AA5A5, 1'b0));
    vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'hFFFFFC06, 32'h0000C3D2, 32'h0,   1'b0));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h004, 32'h0,        32'hC3D20000, 1'b1 & 1'b0));

    // word @0x04 is half-written above; prime its low half first
    vecs.insert(19, mk(1'b1, 2'b10, 1'b0, 32'h04, 32'h00000000, 32'h0, 1'b0));

    foreach (vecs[i]) begin
      model_access(vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].ad, vecs[i].wd, erd, eer);
      run_check($sformatf("vec%0d", i), vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].ad,
                vecs[i].wd, vecs[i].exp_rd, vecs[i].exp_er);
    end

    // Held req_valid: ready once per W+2 cycles, never while busy.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b10;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h10;
    @(posedge clk);
    #1;
    bad_ready = 0; bad_busy = 0; pulses = 0;
    for (int k = 0; k < 3 * (W + 2); k++) begin
      if (bus.req_ready !== ((k % (W + 2)) == W + 1)) bad_ready++;
      if (bus.busy !== !bus.req_ready) bad_busy++;
      if (bus.rsp_valid === 1'b1) pulses++;
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    chk("hold_ready_pattern", 32'(bad_ready), 32'd0);
    chk("hold_busy_vs_ready", 32'(bad_busy), 32'd0);
    chk("hold_rsp_pulses", 32'(pulses), 32'd3);
    g = 0;
    while (bus.busy && g < 20) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("hold_drain", 32'(bus.busy), 32'd0);

    // Reset during the WAIT phase of a store discards it.
    model_access(1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678, erd, eer);
    run_check("pre_rst_store", 1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678, 32'h0, 1'b0);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_size   = 2'b10;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h40;
    bus.req_wdata  = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_store_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(bus.req_ready), 32'd1);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("midrst_rsp_err", 32'(bus.rsp_err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_check("post_rst_load", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h12345678, 1'b0);

    // Randomized phase over words 0x80..0xBF with random wrap bits.
    for (int i = 0; i < 16; i++) begin
      logic [31:0] d;
      d = $urandom;
      model_access(1'b1, 2'b10, 1'b0, 32'h80 + 32'(4 * i), d, erd, eer);
      run_check($sformatf("fill%0d", i), 1'b1, 2'b10, 1'b0, 32'h80 + 32'(4 * i), d, erd, eer);
    end
    for (int i = 0; i < 80; i++) begin
      logic        wr, sg;
      logic [1:0]  sz;
      logic [31:0] ad, wd;
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      ad = ($urandom & 32'hFFFF_FC00) | 32'h80 | 32'($urandom_range(0, 63));
      wd = $urandom;
      model_access(wr, sz, sg, ad, wd, erd, eer);
      run_check($sformatf("rnd%0d", i), wr, sz, sg, ad, wd, erd, eer);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
